sa_input_skewer: RTL and testbench

//  Read side of the async input FIFO, in the systolic-array clock domain; feeds the 3-lane systolic array.

---
 rtl/sa_input_skewer.sv | 150 +++++++++++++++
 tb/tb_sa_input_skewer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_input_skewer.sv
// rtl/sa_input_skewer.sv - FIFO read side feeding weights and diagonally skewed rows to the systolic array
module sa_input_skewer #(
    parameter int DSIZE     = 32,
    parameter int LANES     = 3,
    parameter int LANE_W    = 8,
    parameter int NUM_W     = 3,
    parameter int NUM_ROWS  = 6,
    parameter int FLUSH_CYC = 5,
    localparam int WIW      = (NUM_W > 1) ? $clog2(NUM_W) : 1,
    localparam int RCW      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int FCW      = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [DSIZE-1:0]         fifo_rdata,
    input  logic                     fifo_rempty,
    output logic                     fifo_rinc,
    output logic                     w_valid,
    output logic [WIW-1:0]           w_idx,
    output logic [DSIZE-1:0]         w_data,
    output logic                     sa_en,
    output logic [LANES*LANE_W-1:0]  sa_in,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIW-1:0]   wcnt_q;
    logic [RCW-1:0]   rcnt_q;
    logic [FCW-1:0]   fcnt_q;
    logic             w_valid_q, sa_en_q;
    logic [WIW-1:0]   w_idx_q;
    logic [DSIZE-1:0] w_data_q;
    logic             pop, adv, flush, clr;

    assign clr = (state_q == S_IDLE) && start;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        adv     = 1'b0;
        flush   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD_W;
            end
            S_LOAD_W: begin
                pop = !fifo_rempty;
                if (pop && wcnt_q == WIW'(NUM_W - 1)) state_d = S_STREAM;
            end
            S_STREAM: begin
                pop = !fifo_rempty;
                adv = pop;
                if (pop && rcnt_q == RCW'(NUM_ROWS - 1)) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                adv   = 1'b1;
                flush = 1'b1;
                if (fcnt_q == FCW'(FLUSH_CYC - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            fcnt_q    <= '0;
            w_valid_q <= 1'b0;
            w_idx_q   <= '0;
            w_data_q  <= '0;
            sa_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_valid_q <= pop && (state_q == S_LOAD_W);
            sa_en_q   <= adv;
            if (clr) begin
                wcnt_q <= '0;
                rcnt_q <= '0;
                fcnt_q <= '0;
            end else begin
                if (pop && state_q == S_LOAD_W) begin
                    wcnt_q   <= wcnt_q + WIW'(1);
                    w_idx_q  <= wcnt_q;
                    w_data_q <= fifo_rdata;
                end
                if (pop && state_q == S_STREAM) rcnt_q <= rcnt_q + RCW'(1);
                if (flush) fcnt_q <= fcnt_q + FCW'(1);
            end
        end
    end

    // Lane k: k delay stages then the output stage, all advancing together so a stall freezes the diagonal
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [LANE_W-1:0] in_w;
        logic [LANE_W-1:0] lane_q;

        assign in_w = flush ? '0 : fifo_rdata[k*LANE_W +: LANE_W];
        assign sa_in[k*LANE_W +: LANE_W] = lane_q;

        if (k == 0) begin : g_direct
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)   lane_q <= '0;
                else if (clr) lane_q <= '0;
                else if (adv) lane_q <= in_w;
            end
        end else begin : g_delayed
            logic [LANE_W-1:0] dly_q [k];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_q <= '0;
                    for (int j = 0; j < k; j++) dly_q[j] <= '0;
                end else if (clr) begin
                    lane_q <= '0;
                    for (int j = 0; j < k; j++) dly_q[j] <= '0;
                end else if (adv) begin
                    lane_q   <= dly_q[k-1];
                    dly_q[0] <= in_w;
                    for (int j = 1; j < k; j++) dly_q[j] <= dly_q[j-1];
                end
            end
        end
    end

    assign fifo_rinc = pop;
    assign w_valid   = w_valid_q;
    assign w_idx     = w_idx_q;
    assign w_data    = w_data_q;
    assign sa_en     = sa_en_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_sa_input_skewer.sv
// tb/tb_sa_input_skewer.sv - randomized bench for sa_input_skewer against a queue-based job model
module tb_sa_input_skewer;

    localparam int NUM_W     = 3;
    localparam int NUM_ROWS  = 6;
    localparam int FLUSH_CYC = 5;
    localparam int BEATS     = NUM_ROWS + FLUSH_CYC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] fifo_rdata;
    logic        fifo_rempty;
    logic        fifo_rinc;
    logic        w_valid;
    logic [1:0]  w_idx;
    logic [31:0] w_data;
    logic        sa_en;
    logic [23:0] sa_in;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    sa_input_skewer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .fifo_rdata  (fifo_rdata),
        .fifo_rempty (fifo_rempty),
        .fifo_rinc   (fifo_rinc),
        .w_valid     (w_valid),
        .w_idx       (w_idx),
        .w_data      (w_data),
        .sa_en       (sa_en),
        .sa_in       (sa_in),
        .busy        (busy),
        .done        (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [31:0] fifo_q [$];
    logic [31:0] jw [$];
    logic [31:0] jr [$];
    logic [23:0] beats [$];
    logic [33:0] wlog [$];
    int          wcyc [$];
    int          stall_cnt, stall_at, stall_len, start_at, pops, cyc, done_cnt, stall_obs;
    bit          stall_done, start_done;
    logic [23:0] last_sa_in;

    function automatic void drive_fifo();
        fifo_rempty = (fifo_q.size() == 0) || (stall_cnt > 0);
        fifo_rdata  = (fifo_q.size() != 0) ? fifo_q[0] : $urandom;
    endfunction

    // Beat b carries lane k of row b-k; anything outside the row range is a zero flush value
    function automatic logic [23:0] exp_beat(input int b);
        logic [23:0] res = '0;
        for (int k = 0; k < 3; k++) begin
            int r = b - k;
            if (r >= 0 && r < NUM_ROWS)
                res = res | 24'(((jr[r] >> (8 * k)) & 32'hFF) << (8 * k));
        end
        return res;
    endfunction

    task automatic step();
        bit pop, was_stall;
        @(negedge clk);
        check("rinc_while_empty", 64'(fifo_rinc & fifo_rempty), 64'd0);
        pop        = fifo_rinc;
        was_stall  = (stall_cnt > 0);
        last_sa_in = sa_in;
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        if (pop) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        if (stall_cnt > 0) stall_cnt--;
        if (!stall_done && stall_at >= 0 && pops == NUM_W + stall_at) begin
            stall_cnt  = stall_len;
            stall_done = 1'b1;
        end
        if (!start_done && start_at >= 0 && pops == NUM_W + start_at) begin
            start      = 1'b1;
            start_done = 1'b1;
        end
        drive_fifo();
        if (sa_en) beats.push_back(sa_in);
        if (w_valid) begin
            wlog.push_back({w_idx, w_data});
            wcyc.push_back(cyc);
        end
        if (done) done_cnt++;
        if (was_stall) begin
            stall_obs++;
            check("stall_sa_en", 64'(sa_en), 64'd0);
            check("stall_sa_in_hold", 64'(sa_in), 64'(last_sa_in));
        end
    endtask

    function automatic void load_directed();
        jw.delete();
        jr.delete();
        jw.push_back(32'h11);
        jw.push_back(32'h22);
        jw.push_back(32'h33);
        for (int n = 0; n < NUM_ROWS; n++)
            jr.push_back({8'h00, 8'(3 * n + 3), 8'(3 * n + 2), 8'(3 * n + 1)});
    endfunction

    function automatic void load_random();
        jw.delete();
        jr.delete();
        for (int i = 0; i < NUM_W; i++) jw.push_back($urandom);
        for (int i = 0; i < NUM_ROWS; i++) jr.push_back($urandom);
    endfunction

    task automatic run_job(input string name, input int st_at, input int st_len,
                           input int sta_at, input int extra);
        int n;
        beats.delete();
        wlog.delete();
        wcyc.delete();
        done_cnt   = 0;
        stall_obs  = 0;
        pops       = 0;
        stall_cnt  = 0;
        stall_at   = st_at;
        stall_len  = st_len;
        start_at   = sta_at;
        stall_done = 1'b0;
        start_done = 1'b0;
        foreach (jw[i]) fifo_q.push_back(jw[i]);
        foreach (jr[i]) fifo_q.push_back(jr[i]);
        for (int i = 0; i < extra; i++) fifo_q.push_back($urandom);
        drive_fifo();
        start = 1'b1;
        n = 0;
        while (done_cnt == 0 && n < 300) begin
            step();
            n++;
        end
        check({name, "_done_seen"}, 64'(done_cnt), 64'd1);
        step();
        check({name, "_done_once"}, 64'(done_cnt), 64'd1);
        check({name, "_idle_busy"}, 64'(busy), 64'd0);
        check({name, "_w_count"}, 64'(wlog.size()), 64'(NUM_W));
        for (int i = 0; i < NUM_W && i < wlog.size(); i++) begin
            check($sformatf("%s_w%0d", name, i), 64'(wlog[i]), 64'({2'(i), jw[i]}));
            check($sformatf("%s_w%0d_cycle", name, i), 64'(wcyc[i] - wcyc[0]), 64'(i));
        end
        check({name, "_beat_count"}, 64'(beats.size()), 64'(BEATS));
        for (int b = 0; b < BEATS && b < beats.size(); b++)
            check($sformatf("%s_beat%0d", name, b), 64'(beats[b]), 64'(exp_beat(b)));
        check({name, "_stall_cycles"}, 64'(stall_obs), 64'((st_at >= 0) ? st_len : 0));
        check({name, "_leftover"}, 64'(fifo_q.size()), 64'(extra));
        fifo_q.delete();
        stall_at = -1;
        start_at = -1;
        drive_fifo();
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        stall_cnt = 0;
        stall_at  = -1;
        start_at  = -1;
        cyc       = 0;
        drive_fifo();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sa_en", 64'(sa_en), 64'd0);
        check("rst_sa_in", 64'(sa_in), 64'd0);
        check("rst_w_valid", 64'(w_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;

        load_directed();
        run_job("dir", -1, 0, -1, 0);
        if (beats.size() >= 3) begin
            check("dir_b0_const", 64'(beats[0]), 64'h000001);
            check("dir_b1_const", 64'(beats[1]), 64'h000204);
            check("dir_b2_const", 64'(beats[2]), 64'h030507);
        end

        load_directed();
        run_job("stall", 3, 4, -1, 0);

        load_directed();
        run_job("ign_start", -1, 0, 2, 3);

        load_random();
        run_job("b2b_first", -1, 0, -1, 0);
        load_directed();
        run_job("b2b_second", -1, 0, -1, 0);

        for (int t = 0; t < 4; t++) begin
            load_random();
            run_job($sformatf("rnd%0d", t), int'($urandom_range(1, NUM_ROWS - 1)),
                    int'($urandom_range(1, 6)), int'($urandom_range(0, NUM_ROWS - 1)),
                    int'($urandom_range(0, 3)));
        end

        load_directed();
        beats.delete();
        pops = 0;
        foreach (jw[i]) fifo_q.push_back(jw[i]);
        foreach (jr[i]) fifo_q.push_back(jr[i]);
        drive_fifo();
        start = 1'b1;
        repeat (NUM_W + 4) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_sa_en", 64'(sa_en), 64'd0);
        check("arst_sa_in", 64'(sa_in), 64'd0);
        check("arst_w_valid", 64'(w_valid), 64'd0);
        check("arst_w_idx", 64'(w_idx), 64'd0);
        check("arst_w_data", 64'(w_data), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_rinc", 64'(fifo_rinc), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_rinc%0d", i), 64'(fifo_rinc), 64'd0);
            check($sformatf("post_rst_busy%0d", i), 64'(busy), 64'd0);
        end
        fifo_q.delete();

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
